// File: rtl/busmatrix.sv
// Data-bus interconnect: core/debug read master and core write master to NDEV slaves.
// Decode and enables are combinational; read data returns 1 cycle after acceptance; a busy hit device stalls its channel via m_busy.
module busmatrix #(
  parameter int                 NDEV      = 4,
  parameter int                 AW        = 32,
  parameter int                 DW        = 32,
  parameter logic [NDEV*AW-1:0] BASES     = '0,
  parameter logic [NDEV*8-1:0]  LBITS     = {NDEV{8'd4}},
  parameter logic [DW-1:0]      MISS_DATA = 32'hDEADBEEF
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               m_r_en,
  input  logic [AW-1:0]      m_r_addr,
  output logic [DW-1:0]      m_r_data,
  input  logic               m_w_en,
  input  logic [AW-1:0]      m_w_addr,
  input  logic [DW-1:0]      m_w_data,
  output logic               m_busy,
  input  logic               dbg_own,
  input  logic               dbg_r_en,
  input  logic [AW-1:0]      dbg_r_addr,
  output logic [DW-1:0]      dbg_r_data,
  output logic [NDEV-1:0]    d_r_en,
  output logic [AW-1:0]      d_r_addr,
  input  logic [NDEV*DW-1:0] d_r_data,
  output logic [NDEV-1:0]    d_w_en,
  output logic [AW-1:0]      d_w_addr,
  output logic [DW-1:0]      d_w_data,
  input  logic [NDEV-1:0]    d_busy,
  output logic               fault,
  output logic [AW-1:0]      fault_addr,
  input  logic               fault_clr
);

  localparam int IW = (NDEV > 1) ? $clog2(NDEV) : 1;

  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_hit, wr_hit;
  logic [IW-1:0] rd_idx, wr_idx;
  logic [AW-1:0] rd_mask, wr_mask;
  logic          rd_busy, wr_busy;
  logic          rd_go, wr_go;
  logic          rd_stall, wr_stall;
  logic          rd_miss, wr_miss;
  logic          rsel_vld;
  logic [IW-1:0] rsel_idx;
  logic [DW-1:0] rdata;

  function automatic logic [AW-1:0] win_mask(input int i);
    return (AW'(1) << LBITS[i*8 +: 8]) - AW'(1);
  endfunction

  // Debug ownership takes the whole read channel; writes always come from the core.
  assign rd_en   = dbg_own ? dbg_r_en   : m_r_en;
  assign rd_addr = dbg_own ? dbg_r_addr : m_r_addr;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    logic [AW-1:0] m;
    m       = '0;
    rd_hit  = 1'b0;
    rd_idx  = '0;
    rd_mask = '0;
    wr_hit  = 1'b0;
    wr_idx  = '0;
    wr_mask = '0;
    for (int i = NDEV-1; i >= 0; i--) begin
      m = win_mask(i);
      if ((rd_addr & ~m) == (BASES[i*AW +: AW] & ~m)) begin
        rd_hit  = 1'b1;
        rd_idx  = IW'(i);
        rd_mask = m;
      end
      if ((m_w_addr & ~m) == (BASES[i*AW +: AW] & ~m)) begin
        wr_hit  = 1'b1;
        wr_idx  = IW'(i);
        wr_mask = m;
      end
    end
  end

  assign rd_busy  = rd_hit & d_busy[rd_idx];
  assign wr_busy  = wr_hit & d_busy[wr_idx];
  assign rd_go    = rd_en & ~rd_busy;
  assign wr_go    = m_w_en & ~wr_busy;
  assign rd_stall = (dbg_own & m_r_en) | (rd_en & rd_busy);
  assign wr_stall = m_w_en & wr_busy;
  assign m_busy   = rd_stall | wr_stall;
  assign rd_miss  = rd_en & ~rd_hit;
  assign wr_miss  = m_w_en & ~wr_hit;

  always_comb begin
    d_r_en = '0;
    d_w_en = '0;
    if (rd_go && rd_hit) d_r_en[rd_idx] = 1'b1;
    if (wr_go && wr_hit) d_w_en[wr_idx] = 1'b1;
  end

  assign d_r_addr = rd_hit ? (rd_addr & rd_mask) : '0;
  assign d_w_addr = wr_hit ? (m_w_addr & wr_mask) : '0;
  assign d_w_data = m_w_data;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rsel_vld   <= 1'b0;
      rsel_idx   <= '0;
      fault      <= 1'b0;
      fault_addr <= '0;
    end else begin
      if (rd_go) begin
        rsel_vld <= rd_hit;
        rsel_idx <= rd_idx;
      end
      // A new miss outranks a clear; the write address wins a same-cycle double miss.
      if (wr_miss || rd_miss) begin
        fault      <= 1'b1;
        fault_addr <= wr_miss ? m_w_addr : rd_addr;
      end else if (fault_clr) begin
        fault <= 1'b0;
      end
    end
  end

  assign rdata      = rsel_vld ? d_r_data[int'(rsel_idx)*DW +: DW] : MISS_DATA;
  assign m_r_data   = rdata;
  assign dbg_r_data = rdata;

endmodule

// File: tb/tb_busmatrix.sv
// Directed bench for busmatrix: gpio at 0x10 (16 B window) and memory at 0x1000 (4 KiB window).
module tb_busmatrix;
  logic        clk, n_rst;
  logic        m_r_en, m_w_en, m_busy;
  logic [31:0] m_r_addr, m_r_data, m_w_addr, m_w_data;
  logic        dbg_own, dbg_r_en;
  logic [31:0] dbg_r_addr, dbg_r_data;
  logic [1:0]  d_r_en, d_w_en, d_busy;
  logic [31:0] d_r_addr, d_w_addr, d_w_data;
  logic [63:0] d_r_data;
  logic        fault, fault_clr;
  logic [31:0] fault_addr;
  logic [31:0] mem0, mem1;
  int          tests = 0;
  int          fails = 0;

  busmatrix #(
    .NDEV(2), .AW(32), .DW(32),
    .BASES({32'h0000_1000, 32'h0000_0010}),
    .LBITS({8'd12, 8'd4}),
    .MISS_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .m_r_en(m_r_en), .m_r_addr(m_r_addr), .m_r_data(m_r_data),
    .m_w_en(m_w_en), .m_w_addr(m_w_addr), .m_w_data(m_w_data), .m_busy(m_busy),
    .dbg_own(dbg_own), .dbg_r_en(dbg_r_en), .dbg_r_addr(dbg_r_addr), .dbg_r_data(dbg_r_data),
    .d_r_en(d_r_en), .d_r_addr(d_r_addr), .d_r_data(d_r_data),
    .d_w_en(d_w_en), .d_w_addr(d_w_addr), .d_w_data(d_w_data),
    .d_busy(d_busy),
    .fault(fault), .fault_addr(fault_addr), .fault_clr(fault_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous device models: data tags the device and echoes the local address.
  always @(posedge clk) begin
    if (d_r_en[0]) mem0 <= 32'h2222_0000 | d_r_addr;
    if (d_r_en[1]) mem1 <= 32'h1111_0000 | d_r_addr;
  end
  assign d_r_data = {mem1, mem0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_rst = 1'b0; m_r_en = 0; m_r_addr = 0; m_w_en = 0; m_w_addr = 0; m_w_data = 0;
    dbg_own = 0; dbg_r_en = 0; dbg_r_addr = 0; d_busy = 0; fault_clr = 0;
    mem0 = 32'h0; mem1 = 32'h0;
    #2;
    chk("rst_rdata", m_r_data, 32'hDEADBEEF);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_faddr", fault_addr, 32'h0);
    step();
    n_rst = 1'b1;
    step();

    // 1: write to memory
    m_w_en = 1; m_w_addr = 32'h1008; m_w_data = 32'hA5;
    #1;
    chk("w_en", {30'b0, d_w_en}, 32'b10);
    chk("w_addr", d_w_addr, 32'h008);
    chk("w_data", d_w_data, 32'hA5);
    chk("w_busy", {31'b0, m_busy}, 32'd0);
    step();
    m_w_en = 0;

    // 2: back-to-back reads to different devices
    m_r_en = 1; m_r_addr = 32'h1004;
    #1;
    chk("r1_en", {30'b0, d_r_en}, 32'b10);
    chk("r1_addr", d_r_addr, 32'h004);
    step();
    chk("r1_data", m_r_data, 32'h1111_0004);
    m_r_addr = 32'h0014;
    #1;
    chk("r2_en", {30'b0, d_r_en}, 32'b01);
    chk("r2_addr", d_r_addr, 32'h4);
    step();
    m_r_en = 0;
    chk("r2_data", m_r_data, 32'h2222_0004);
    chk("r2_dbgdata", dbg_r_data, 32'h2222_0004);
    step();
    chk("r2_hold", m_r_data, 32'h2222_0004);

    // 3: read miss, then clear colliding with a write miss
    m_r_en = 1; m_r_addr = 32'h2000;
    #1;
    chk("miss_en", {30'b0, d_r_en}, 32'b00);
    chk("miss_addr", d_r_addr, 32'h0);
    step();
    m_r_en = 0;
    chk("miss_data", m_r_data, 32'hDEADBEEF);
    chk("miss_fault", {31'b0, fault}, 32'd1);
    chk("miss_faddr", fault_addr, 32'h2000);
    fault_clr = 1; m_w_en = 1; m_w_addr = 32'h3000;
    #1;
    chk("wmiss_en", {30'b0, d_w_en}, 32'b00);
    step();
    m_w_en = 0;
    chk("clrmiss_fault", {31'b0, fault}, 32'd1);
    chk("clrmiss_faddr", fault_addr, 32'h3000);
    step();
    fault_clr = 0;
    chk("clr_fault", {31'b0, fault}, 32'd0);
    chk("clr_faddr", fault_addr, 32'h3000);

    // 4: busy device stalls the read until released
    d_busy = 2'b10; m_r_en = 1; m_r_addr = 32'h1000;
    #1;
    chk("busy_mbusy", {31'b0, m_busy}, 32'd1);
    chk("busy_en", {30'b0, d_r_en}, 32'b00);
    step();
    chk("busy_noacc", m_r_data, 32'hDEADBEEF);
    d_busy = 2'b00;
    #1;
    chk("rel_mbusy", {31'b0, m_busy}, 32'd0);
    chk("rel_en", {30'b0, d_r_en}, 32'b10);
    step();
    m_r_en = 0;
    chk("rel_data", m_r_data, 32'h1111_0000);

    // 5: debug owns the read channel, core write still goes through
    dbg_own = 1; dbg_r_en = 1; dbg_r_addr = 32'h1FFC;
    m_r_en = 1; m_r_addr = 32'h1000;
    m_w_en = 1; m_w_addr = 32'h0010; m_w_data = 32'h5A;
    #1;
    chk("dbg_en", {30'b0, d_r_en}, 32'b10);
    chk("dbg_addr", d_r_addr, 32'hFFC);
    chk("dbg_mbusy", {31'b0, m_busy}, 32'd1);
    chk("dbg_wen", {30'b0, d_w_en}, 32'b01);
    chk("dbg_waddr", d_w_addr, 32'h0);
    step();
    dbg_own = 0; dbg_r_en = 0; m_r_en = 0; m_w_en = 0;
    chk("dbg_data", dbg_r_data, 32'h1111_0FFC);

    // 6: miss then dev1 read, then asynchronous reset
    m_r_en = 1; m_r_addr = 32'h5000;
    step();
    m_r_addr = 32'h1008;
    step();
    m_r_en = 0;
    chk("pre_rst_data", m_r_data, 32'h1111_0008);
    chk("pre_rst_fault", {31'b0, fault}, 32'd1);
    n_rst = 0;
    #1;
    chk("arst_data", m_r_data, 32'hDEADBEEF);
    chk("arst_fault", {31'b0, fault}, 32'd0);
    chk("arst_faddr", fault_addr, 32'h0);
    step();
    n_rst = 1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
